// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default bit timing.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 5208;  // 50 MHz / 9600 baud

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous level; both flops reset to 1 (idle line level).
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so meta->q forms a real two-stage shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8-bit UART receiver (8N1; 8E1/8O1 when UART_RX_PARITY_EN is defined) with mid-bit sampling,
// frame-error detection and a break state that reports a held-low line only once.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int PARITY_ODD   = 0
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RX_IN,
  output logic       RX_DV,
  output logic [7:0] RX_Byte,
  output logic       RX_Active,
  output logic       RX_FRAME_ERR,
  output logic       RX_PARITY_ERR
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_rx: CLKS_PER_BIT must be >= 4 and PARITY_ODD must be 0 or 1");
  end

  logic          rx_s;
  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    byte_q, byte_d;
  logic          dv_q, dv_d;
  logic          ferr_q, ferr_d;

`ifdef UART_RX_PARITY_EN
  localparam logic ODD = 1'(PARITY_ODD);
  logic par_q, par_d;
  logic perr_q, perr_d;
`endif

  uart_sync2 u_sync (
    .clk  (CLK),
    .rst_n(RST_N),
    .d    (RX_IN),
    .q    (rx_s)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the data shift register is reset along with control; a reset mid-frame leaves no stale bits.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      data_q <= '0;
      byte_q <= '0;
      dv_q   <= 1'b0;
      ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q  <= 1'b0;
      perr_q <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      data_q <= data_d;
      byte_q <= byte_d;
      dv_q   <= dv_d;
      ferr_q <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q  <= par_d;
      perr_q <= perr_d;
`endif
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    byte_d  = byte_q;
    dv_d    = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          cnt_d   = '0;
          state_d = START;
        end
      end

      // Re-check the start bit at its midpoint to reject short glitches.
      START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d         = '0;
          data_d[idx_q] = rx_s;
          idx_d         = idx_q + 1'b1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif

      // Leave at mid-stop so a following start bit is never missed.
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_d  = data_q;
            dv_d    = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = ((^data_q) ^ par_q) != ODD;
`endif
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign RX_DV        = dv_q;
  assign RX_Byte      = byte_q;
  assign RX_Active    = (state_q != IDLE);
  assign RX_FRAME_ERR = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign RX_PARITY_ERR = perr_q;
`else
  assign RX_PARITY_ERR = 1'b0;
`endif

endmodule
